// File: rtl/esu_pkg.sv
// Shared types and helpers for the event-scheduling unit.
//   esu_state_e : controller states (IDLE, DIV, OUT)
//   esu_flags_t : per-result flag bundle {dir, zero_v, sat}
//   rr_pick     : round-robin grant index, searching upward from ptr+1 with wrap
package esu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      OUT  = 2'd2
   } esu_state_e;

   typedef struct packed {
      logic dir;
      logic zero_v;
      logic sat;
   } esu_flags_t;

   // rr_pick works on a fixed-width request vector; callers zero-extend.
   localparam int unsigned ESU_MAX_CH  = 32;
   localparam int unsigned ESU_MAX_CHW = 5;

   // Returns the first requesting index after ptr (wrapping at nch).
   // With no request set the result is ptr; callers qualify with |req.
   function automatic int unsigned rr_pick(input logic [ESU_MAX_CH-1:0] req,
                                           input int unsigned          ptr,
                                           input int unsigned          nch);
      logic [31:0] idx;
      logic        found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int unsigned k = 1; k <= ESU_MAX_CH; k++) begin
         idx = ptr + k;
         if (idx >= nch) idx = idx - nch;
         if (!found && (k <= nch) && req[idx[ESU_MAX_CHW-1:0]]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/esu_mc_if.sv
// Request/result bus of the event-scheduling unit.
//   req_valid/req_ready : per-channel request handshake (NCH bits)
//   t_up/t_on/velocity  : per-channel operands, channel i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready : result handshake
//   out_ch/t_off/dir/zero_v/sat : tagged result
// master = requesters/consumer side, slave = esu_mc.
interface esu_mc_if #(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]       req_valid;
   logic [NCH-1:0]       req_ready;
   logic [NCH*WIDTH-1:0] t_up;
   logic [NCH*WIDTH-1:0] t_on;
   logic [NCH*WIDTH-1:0] velocity;
   logic                 out_valid;
   logic                 out_ready;
   logic [CHW-1:0]       out_ch;
   logic [WIDTH-1:0]     t_off;
   logic                 dir;
   logic                 zero_v;
   logic                 sat;

   modport master (
      output req_valid, t_up, t_on, velocity, out_ready,
      input  req_ready, out_valid, out_ch, t_off, dir, zero_v, sat
   );

   modport slave (
      input  req_valid, t_up, t_on, velocity, out_ready,
      output req_ready, out_valid, out_ch, t_off, dir, zero_v, sat
   );

endinterface

// File: rtl/esu_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
//   clk, N_reset : clock, synchronous active-low reset (aborts a division)
//   start        : begin a = q*b + r; ignored while a division is running
//   a, b         : dividend, divisor (b != 0 expected)
//   q, r         : quotient, remainder; valid while done is high
//   done         : single-cycle pulse WIDTH cycles after start
// The first quotient bit is resolved on the start edge itself so that the
// registered result and done line up exactly WIDTH cycles after start.
module esu_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             N_reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             done
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             done_q, done_d;

   logic             load;
   logic [WIDTH-1:0] src_acc, src_rem, src_b;
   logic [WIDTH:0]   rem_sh, diff, acc_next;

   always_comb begin
      load    = start && !busy_q;
      src_acc = load ? a : acc_q;
      src_rem = load ? '0 : rem_q;
      src_b   = load ? b : dvs_q;
      rem_sh  = {src_rem, src_acc[WIDTH-1]};
      diff    = rem_sh - {1'b0, src_b};

      busy_d   = busy_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      done_d   = 1'b0;
      acc_next = '0;

      if (load || busy_q) begin
         dvs_d = src_b;
         // borrow out of the trial subtraction means rem_sh < divisor
         if (!diff[WIDTH]) begin
            rem_d    = diff[WIDTH-1:0];
            acc_next = {src_acc, 1'b1};
         end else begin
            rem_d    = rem_sh[WIDTH-1:0];
            acc_next = {src_acc, 1'b0};
         end
         acc_d = acc_next[WIDTH-1:0];
         cnt_d = load ? CW'(WIDTH - 1) : cnt_q - CW'(1);
         if (cnt_d == '0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            busy_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!N_reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         done_q <= done_d;
      end
   end

   assign q    = acc_q;
   assign r    = rem_q;
   assign done = done_q;

endmodule

// File: rtl/esu_mc.sv
// Multi-channel event-scheduling unit: t_off = t_up / |velocity| - t_on,
// dir = sign(velocity). NCH channels share one divider, granted round-robin.
//   clk, N_reset : clock, synchronous active-low reset
//   bus          : esu_mc_if slave (requests in, tagged results out)
//   busy         : controller is not in IDLE
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | arbitrate; accept one request, latch operands
//   DIV   | divider running (started the cycle after accept)
//   OUT   | result registered, held until out_ready
module esu_mc
   import esu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 4
) (
   input  logic     clk,
   input  logic     N_reset,
   esu_mc_if.slave  bus,
   output logic     busy
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_DIV  = 2'(DIV);
   localparam logic [1:0] ST_OUT  = 2'(OUT);

   logic [1:0]       state_q, state_d;
   logic [CHW-1:0]   rr_q, rr_d;
   logic [CHW-1:0]   ch_q, ch_d;
   logic [WIDTH-1:0] t_up_q, t_up_d;
   logic [WIDTH-1:0] t_on_q, t_on_d;
   logic [WIDTH-1:0] speed_q, speed_d;
   logic             dir_q, dir_d;
   logic             start_q, start_d;
   logic             out_valid_q, out_valid_d;
   logic [CHW-1:0]   out_ch_q, out_ch_d;
   logic [WIDTH-1:0] t_off_q, t_off_d;
   esu_flags_t       flags_q, flags_d;

   logic [ESU_MAX_CH-1:0] req_ext;
   logic [CHW-1:0]        gnt_ch;
   logic                  hs;
   logic [NCH-1:0]        ready_vec;
   logic [WIDTH-1:0]      t_up_in, t_on_in, vel_in, speed_in;

   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] div_r_unused;
   logic             div_done;

   esu_divider #(.WIDTH(WIDTH)) u_div (
      .clk     (clk),
      .N_reset (N_reset),
      .start   (start_q),
      .a       (t_up_q),
      .b       (speed_q),
      .q       (div_q),
      .r       (div_r_unused),
      .done    (div_done)
   );

   // Arbiter and operand mux for the granted channel.
   always_comb begin
      req_ext            = '0;
      req_ext[NCH-1:0]   = bus.req_valid;
      gnt_ch             = CHW'(rr_pick(req_ext, 32'(rr_q), 32'(NCH)));
      // req_ready is gated by reset so nothing is accepted on a reset edge
      hs                 = N_reset && (state_q == ST_IDLE) && (|bus.req_valid);
      ready_vec          = '0;
      t_up_in            = '0;
      t_on_in            = '0;
      vel_in             = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt_ch == CHW'(i)) begin
            ready_vec[i] = hs;
            t_up_in      = bus.t_up[i*WIDTH +: WIDTH];
            t_on_in      = bus.t_on[i*WIDTH +: WIDTH];
            vel_in       = bus.velocity[i*WIDTH +: WIDTH];
         end
      end
      // most negative velocity maps to 2^(WIDTH-1) as an unsigned magnitude
      speed_in = vel_in[WIDTH-1] ? -vel_in : vel_in;
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      ch_d        = ch_q;
      t_up_d      = t_up_q;
      t_on_d      = t_on_q;
      speed_d     = speed_q;
      dir_d       = dir_q;
      start_d     = 1'b0;
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      t_off_d     = t_off_q;
      flags_d     = flags_q;

      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               ch_d    = gnt_ch;
               rr_d    = gnt_ch;
               t_up_d  = t_up_in;
               t_on_d  = t_on_in;
               speed_d = speed_in;
               dir_d   = vel_in[WIDTH-1];
               if (speed_in == '0) begin
                  state_d        = ST_OUT;
                  out_valid_d    = 1'b1;
                  out_ch_d       = gnt_ch;
                  t_off_d        = '1;
                  flags_d.dir    = vel_in[WIDTH-1];
                  flags_d.zero_v = 1'b1;
                  flags_d.sat    = 1'b0;
               end else begin
                  state_d = ST_DIV;
                  start_d = 1'b1;
               end
            end
         end
         ST_DIV: begin
            if (div_done) begin
               state_d        = ST_OUT;
               out_valid_d    = 1'b1;
               out_ch_d       = ch_q;
               flags_d.dir    = dir_q;
               flags_d.zero_v = 1'b0;
               if (div_q < t_on_q) begin
                  t_off_d     = '0;
                  flags_d.sat = 1'b1;
               end else begin
                  t_off_d     = div_q - t_on_q;
                  flags_d.sat = 1'b0;
               end
            end
         end
         ST_OUT: begin
            if (bus.out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!N_reset) begin
         state_q     <= ST_IDLE;
         rr_q        <= CHW'(NCH - 1);
         ch_q        <= '0;
         t_up_q      <= '0;
         t_on_q      <= '0;
         speed_q     <= '0;
         dir_q       <= 1'b0;
         start_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         t_off_q     <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         ch_q        <= ch_d;
         t_up_q      <= t_up_d;
         t_on_q      <= t_on_d;
         speed_q     <= speed_d;
         dir_q       <= dir_d;
         start_q     <= start_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         t_off_q     <= t_off_d;
         flags_q     <= flags_d;
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.t_off     = t_off_q;
   assign bus.dir       = flags_q.dir;
   assign bus.zero_v    = flags_q.zero_v;
   assign bus.sat       = flags_q.sat;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_esu_mc.sv
// Bench for esu_mc: directed requests; expected results are queued when a
// request is issued and a separate monitor compares every presented result.
module tb_esu_mc;
   localparam int W = 32;
   localparam int N = 4;

   logic clk = 1'b0;
   logic N_reset = 1'b0;
   logic busy;

   esu_mc_if #(.WIDTH(W), .NCH(N)) bus ();

   esu_mc #(.WIDTH(W), .NCH(N)) dut (
      .clk     (clk),
      .N_reset (N_reset),
      .bus     (bus),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          ch;
      logic [31:0] t_off;
      logic        dir;
      logic        zv;
      logic        sat;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   hs_q[$];
   int   total = 0;
   int   bad = 0;
   int   hs_count = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   function automatic void push(int ch, logic [31:0] t_off, logic dir, logic zv, logic sat, int lat);
      exp_t e;
      e.ch = ch; e.t_off = t_off; e.dir = dir; e.zv = zv; e.sat = sat; e.lat = lat;
      exp_q.push_back(e);
   endfunction

   // monitor
   logic shown = 1'b0;
   exp_t cur;
   always @(negedge clk) begin
      if (!N_reset) begin
         hs_q.delete();
         shown = 1'b0;
      end else begin
         if (|(bus.req_valid & bus.req_ready)) begin
            hs_q.push_back(cyc);
            hs_count++;
         end
         if (bus.out_valid) begin
            if (!shown) begin
               shown = 1'b1;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_result: got ch=%0d t_off=%0h want no result", bus.out_ch, bus.t_off);
               end else begin
                  cur = exp_q.pop_front();
                  if (hs_q.size() > 0) chk("latency", 64'(cyc - hs_q.pop_front()), 64'(cur.lat));
                  else begin
                     total++;
                     bad++;
                     $display("FAIL latency: got no handshake want one before result");
                  end
               end
            end
            chk("out_ch", 64'(bus.out_ch), 64'(cur.ch));
            chk("t_off", 64'(bus.t_off), 64'(cur.t_off));
            chk("dir", 64'(bus.dir), 64'(cur.dir));
            chk("zero_v", 64'(bus.zero_v), 64'(cur.zv));
            chk("sat", 64'(bus.sat), 64'(cur.sat));
            chk("req_ready_in_out", 64'(bus.req_ready), 64'(0));
            chk("busy_in_out", 64'(busy), 64'(1));
            if (bus.out_ready) shown = 1'b0;
         end
      end
   end

   task automatic set_ch(int ch, logic [31:0] tu, logic [31:0] v, logic [31:0] ton);
      bus.t_up[ch*W +: W]     = tu;
      bus.velocity[ch*W +: W] = v;
      bus.t_on[ch*W +: W]     = ton;
   endtask

   // called just after a rising edge; returns just after the accept edge
   task automatic issue(int ch, logic [31:0] tu, logic [31:0] v, logic [31:0] ton);
      bit got = 1'b0;
      set_ch(ch, tu, v, ton);
      bus.req_valid[ch] = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.req_ready[ch]) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.req_valid[ch] = 1'b0;
      if (!got) chk("grant_timeout", 64'(got), 64'(1));
   endtask

   task automatic drain(int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero_outputs(string tag);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
      chk({tag, "_out_ch"}, 64'(bus.out_ch), 64'(0));
      chk({tag, "_t_off"}, 64'(bus.t_off), 64'(0));
      chk({tag, "_dir"}, 64'(bus.dir), 64'(0));
      chk({tag, "_zero_v"}, 64'(bus.zero_v), 64'(0));
      chk({tag, "_sat"}, 64'(bus.sat), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int target;
      bit seen;
      bus.req_valid = '0;
      bus.t_up      = '0;
      bus.t_on      = '0;
      bus.velocity  = '0;
      bus.out_ready = 1'b1;
      N_reset       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero_outputs("reset");
      @(posedge clk);
      #1;
      N_reset = 1'b1;

      // all channels request continuously: grants 0,1,2,3,0
      for (int c = 0; c < N; c++) set_ch(c, 100, 1, 0);
      push(0, 100, 0, 0, 0, 34);
      push(1, 100, 0, 0, 0, 34);
      push(2, 100, 0, 0, 0, 34);
      push(3, 100, 0, 0, 0, 34);
      push(0, 100, 0, 0, 0, 34);
      target = hs_count + 5;
      bus.req_valid = '1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (hs_count >= target) break;
      end
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      drain(400);

      push(1, 70, 0, 0, 0, 34);
      issue(1, 1000, 10, 30);
      drain(100);

      push(2, 0, 1, 0, 1, 34);
      issue(2, 1000, 32'(-4), 300);
      drain(100);

      push(0, 32'hFFFF_FFFF, 0, 1, 0, 1);
      issue(0, 5, 0, 7);
      drain(100);

      push(3, 1, 1, 0, 0, 34);
      issue(3, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      drain(100);

      push(1, 0, 1, 0, 0, 34);
      issue(1, 5, 32'(-7), 0);
      drain(100);

      push(2, 0, 0, 0, 0, 34);
      issue(2, 100, 10, 10);
      drain(100);

      push(0, 2, 0, 0, 0, 34);
      issue(0, 7, 2, 1);
      drain(100);

      // back-pressure: result held while ch0 waits
      bus.out_ready = 1'b0;
      push(2, 7, 0, 0, 0, 34);
      push(0, 32'hFFFF_FFFF, 0, 1, 0, 1);
      issue(2, 50, 5, 3);
      set_ch(0, 9, 0, 0);
      bus.req_valid[0] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("bp_out_valid_seen", 64'(seen), 64'(1));
      for (int i = 0; i < 10; i++) begin
         chk("bp_hold_valid", 64'(bus.out_valid), 64'(1));
         chk("bp_hold_req_ready", 64'(bus.req_ready), 64'(0));
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_idle_busy", 64'(busy), 64'(0));
      chk("bp_idle_grant", 64'(bus.req_ready), 64'(4'b0001));
      @(posedge clk);
      #1;
      bus.req_valid[0] = 1'b0;
      drain(100);

      // reset during a division drops it
      issue(1, 1000, 10, 30);
      repeat (9) @(posedge clk);
      #1;
      N_reset = 1'b0;
      @(posedge clk);
      #1;
      N_reset = 1'b1;
      @(negedge clk);
      chk_zero_outputs("midreset");
      @(posedge clk);
      #1;
      push(1, 70, 0, 0, 0, 34);
      issue(1, 1000, 10, 30);
      drain(100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
